// File: rtl/eth_fcs_pad.sv
// Ethernet frame tail stage: forwards frame bytes, zero-pads to the minimum length,
// drops over-length bytes and appends the reflected CRC-32 FCS, LS byte first.
module eth_fcs_pad #(
    parameter int MIN_FRAME = 60,
    parameter int MAX_FRAME = 1514
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_start,
    input  logic       in_last,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_start,
    output logic       out_last,
    output logic       err_pulse
);

    typedef enum logic [1:0] {IDLE, PASS, PAD, FCS} state_t;

    localparam logic [31:0] POLY  = 32'hEDB88320;
    localparam logic [10:0] MIN_C = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_C = 11'(MAX_FRAME);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] c);
        return (c >= MAX_C) ? MAX_C : c + 11'd1;
    endfunction

    state_t      state, state_n;
    logic [10:0] cnt, cnt_n;
    logic [31:0] crc, crc_n, crc_eff, fcs_word;
    logic [1:0]  fcs_idx, fcs_idx_n;
    logic        ovf, ovf_n;
    logic        out_fcs, ofcs_n;
    logic [7:0]  od_n;
    logic        ov_n, os_n, ol_n, err_n;
    logic        slot_free, out_fire, in_fire;

    assign slot_free = !out_valid || out_ready;
    assign out_fire  = out_valid && out_ready;
    assign in_ready  = reset_n && (state == IDLE || state == PASS) && slot_free;
    assign in_fire   = in_valid && in_ready;

    // The byte leaving the output register this cycle is folded in before an FCS byte is formed.
    assign crc_eff  = (out_fire && !out_fcs) ? crc_byte(crc, out_data) : crc;
    assign fcs_word = ~crc_eff;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        crc_n     = crc_eff;
        fcs_idx_n = fcs_idx;
        ovf_n     = ovf;
        err_n     = 1'b0;
        od_n      = out_data;
        ov_n      = out_valid && !out_ready;
        os_n      = out_start;
        ol_n      = out_last;
        ofcs_n    = out_fcs;
        unique case (state)
            IDLE: begin
                if (in_fire) begin
                    if (!in_start) begin
                        err_n = 1'b1;
                    end else begin
                        od_n      = in_data;
                        ov_n      = 1'b1;
                        os_n      = 1'b1;
                        ol_n      = 1'b0;
                        ofcs_n    = 1'b0;
                        cnt_n     = 11'd1;
                        ovf_n     = 1'b0;
                        fcs_idx_n = 2'd0;
                        if (in_last)
                            state_n = (11'd1 < MIN_C) ? PAD : FCS;
                        else
                            state_n = PASS;
                    end
                end
            end
            PASS: begin
                if (in_fire) begin
                    if (in_start)
                        err_n = 1'b1;
                    if (cnt >= MAX_C) begin
                        // Over-length bytes are swallowed; flag only the first one.
                        if (!ovf)
                            err_n = 1'b1;
                        ovf_n = 1'b1;
                        if (in_last)
                            state_n = FCS;
                    end else begin
                        od_n   = in_data;
                        ov_n   = 1'b1;
                        os_n   = 1'b0;
                        ol_n   = 1'b0;
                        ofcs_n = 1'b0;
                        cnt_n  = sat_inc(cnt);
                        if (in_last)
                            state_n = (sat_inc(cnt) < MIN_C) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                if (slot_free) begin
                    od_n   = 8'h00;
                    ov_n   = 1'b1;
                    os_n   = 1'b0;
                    ol_n   = 1'b0;
                    ofcs_n = 1'b0;
                    cnt_n  = sat_inc(cnt);
                    if (sat_inc(cnt) >= MIN_C)
                        state_n = FCS;
                end
            end
            FCS: begin
                if (slot_free) begin
                    if (out_valid && out_last) begin
                        state_n = IDLE;
                        crc_n   = 32'hFFFFFFFF;
                    end else begin
                        od_n      = fcs_word[{fcs_idx, 3'b000} +: 8];
                        ov_n      = 1'b1;
                        os_n      = 1'b0;
                        ol_n      = (fcs_idx == 2'd3);
                        ofcs_n    = 1'b1;
                        fcs_idx_n = fcs_idx + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            crc       <= 32'hFFFFFFFF;
            fcs_idx   <= '0;
            ovf       <= 1'b0;
            out_fcs   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_last  <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            crc       <= crc_n;
            fcs_idx   <= fcs_idx_n;
            ovf       <= ovf_n;
            out_fcs   <= ofcs_n;
            out_data  <= od_n;
            out_valid <= ov_n;
            out_start <= os_n;
            out_last  <= ol_n;
            err_pulse <= err_n;
        end
    end

endmodule

// File: tb/tb_eth_fcs_pad.sv
// Scoreboard bench for eth_fcs_pad: a default instance and a small-limit instance
// (MIN_FRAME=9, MAX_FRAME=20) share the stimulus, selected by sel.
module tb_eth_fcs_pad;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       l;
    } beat_t;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid, in_start, in_last;
    logic       sel, rnd_en, rnd_bit;
    logic       out_ready;

    logic       iv_d, iv_s;
    logic       rdy_d, ov_d, os_d, ol_d, er_d;
    logic       rdy_s, ov_s, os_s, ol_s, er_s;
    logic [7:0] od_d, od_s;
    logic       rdy_m, ov_m, os_m, ol_m, er_m;
    logic [7:0] od_m;

    beat_t exp_q[$];
    bq_t   frm;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    beat_cnt = 0;
    int    err_cnt  = 0;

    always #20 clk = ~clk;

    assign out_ready = rnd_en ? rnd_bit : 1'b1;
    assign iv_d = in_valid & ~sel;
    assign iv_s = in_valid & sel;
    assign rdy_m = sel ? rdy_s : rdy_d;
    assign ov_m  = sel ? ov_s  : ov_d;
    assign os_m  = sel ? os_s  : os_d;
    assign ol_m  = sel ? ol_s  : ol_d;
    assign er_m  = sel ? er_s  : er_d;
    assign od_m  = sel ? od_s  : od_d;

    eth_fcs_pad u_def (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(iv_d), .in_ready(rdy_d),
        .in_start(in_start), .in_last(in_last),
        .out_data(od_d), .out_valid(ov_d), .out_ready(out_ready),
        .out_start(os_d), .out_last(ol_d), .err_pulse(er_d)
    );

    eth_fcs_pad #(.MIN_FRAME(9), .MAX_FRAME(20)) u_small (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(iv_s), .in_ready(rdy_s),
        .in_start(in_start), .in_last(in_last),
        .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready),
        .out_start(os_s), .out_last(ol_s), .err_pulse(er_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-32 reference, returns the complemented value that goes on the wire.
    function automatic logic [31:0] crc_model(input bq_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = {1'b0, c[31:1]};
                if (fb)
                    c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic push_wire(input bq_t o);
        beat_t e;
        foreach (o[i]) begin
            e.d = o[i];
            e.s = (i == 0);
            e.l = (i == o.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_expected(input bq_t f, input int min_f, input int max_f);
        bq_t         o;
        logic [31:0] fcs;
        int          keep;
        keep = (f.size() > max_f) ? max_f : f.size();
        for (int i = 0; i < keep; i++)
            o.push_back(f[i]);
        while (o.size() < min_f)
            o.push_back(8'h00);
        fcs = crc_model(o);
        for (int k = 0; k < 4; k++)
            o.push_back(fcs[8*k +: 8]);
        push_wire(o);
    endtask

    task automatic make_frame(input int n);
        frm.delete();
        for (int i = 0; i < n; i++)
            frm.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send(input int n_send);
        int   to;
        logic done;
        for (int i = 0; i < n_send; i++) begin
            in_valid = 1'b1;
            in_data  = frm[i];
            in_start = (i == 0);
            in_last  = (i == frm.size() - 1);
            to   = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                done = rdy_m;
                @(posedge clk);
                #1;
                if (!done) begin
                    to++;
                    if (to > 3000) begin
                        check("in_timeout", 32'(to), 32'd0);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_start = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while ((exp_q.size() != 0 || ov_m) && to < 5000) begin
            @(posedge clk);
            #1;
            to++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: samples on the falling edge, ahead of the transferring rising edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (er_m)
                    err_cnt++;
                if (ov_m && out_ready) begin
                    beat_cnt++;
                    if (exp_q.size() == 0) begin
                        check("sb_extra_beat", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("data",  32'(od_m), 32'(e.d));
                        check("start", 32'(os_m), 32'(e.s));
                        check("last",  32'(ol_m), 32'(e.l));
                    end
                end
            end
        end
    end

    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        bq_t o;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        sel      = 1'b0;
        rnd_en   = 1'b0;
        #5 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(ov_d), 32'd0);
        check("rst_out_data",  32'(od_d), 32'd0);
        check("rst_in_ready",  32'(rdy_d), 32'd0);
        check("rst_err",       32'(er_d), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: check value "123456789", MIN_FRAME=9
        sel = 1'b1;
        beat_cnt = 0;
        frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        o = frm;
        o.push_back(8'h26);
        o.push_back(8'h39);
        o.push_back(8'hF4);
        o.push_back(8'hCB);
        push_wire(o);
        send(9);
        drain();
        check("t1_beats", 32'(beat_cnt), 32'd13);

        // 2: one-byte frame padded to 60
        sel = 1'b0;
        beat_cnt = 0;
        frm = {8'hAB};
        push_expected(frm, 60, 1514);
        send(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_in_ready_low", 32'(rdy_d), 32'd0);
        end
        drain();
        check("t2_beats", 32'(beat_cnt), 32'd64);

        // 3: 100-byte frame, full rate then random backpressure
        make_frame(100);
        for (int pass = 0; pass < 2; pass++) begin
            rnd_en = (pass == 1);
            beat_cnt = 0;
            push_expected(frm, 60, 1514);
            send(100);
            drain();
            check("t3_beats", 32'(beat_cnt), 32'd104);
        end
        rnd_en = 1'b0;

        // 4: over-length on MAX_FRAME=20, then a clean frame
        sel = 1'b1;
        beat_cnt = 0;
        err_cnt = 0;
        make_frame(25);
        push_expected(frm, 9, 20);
        send(25);
        drain();
        check("t4_err_once", 32'(err_cnt), 32'd1);
        check("t4_beats", 32'(beat_cnt), 32'd24);
        beat_cnt = 0;
        err_cnt = 0;
        make_frame(12);
        push_expected(frm, 9, 20);
        send(12);
        drain();
        check("t4_next_err", 32'(err_cnt), 32'd0);
        check("t4_next_beats", 32'(beat_cnt), 32'd16);

        // 5: reset mid-frame, then a fresh frame
        sel = 1'b0;
        make_frame(60);
        push_expected(frm, 60, 1514);
        send(30);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_async_valid", 32'(ov_d), 32'd0);
        @(negedge clk);
        check("t5_rst_data",  32'(od_d), 32'd0);
        check("t5_rst_start", 32'(os_d), 32'd0);
        check("t5_rst_last",  32'(ol_d), 32'd0);
        check("t5_rst_ready", 32'(rdy_d), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        beat_cnt = 0;
        err_cnt = 0;
        make_frame(60);
        push_expected(frm, 60, 1514);
        send(60);
        drain();
        check("t5_beats", 32'(beat_cnt), 32'd64);
        check("t5_err", 32'(err_cnt), 32'd0);

        // 6: byte without in_start while idle
        beat_cnt = 0;
        err_cnt = 0;
        in_valid = 1'b1;
        in_start = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h55;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_err", 32'(err_cnt), 32'd1);
        check("t6_beats", 32'(beat_cnt), 32'd0);
        check("t6_out_valid", 32'(ov_d), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
